// File: rtl/matrix_operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : matrix_operand_loader                                            |
// | Purpose : Packs a serial A-then-B element stream into row vectors of A and |
// |           column vectors of B, then holds both buses until accepted.       |
// | Option  : MATRIX_OPERAND_LOADER_FRAME_CHECK_EN enables the in_last check.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module matrix_operand_loader #(
  parameter int DATA_WIDTH        = 32,
  parameter int SIZE              = 4,
  parameter int OUTPUT_DATA_WIDTH = SIZE*SIZE*DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [OUTPUT_DATA_WIDTH-1:0] data0_out,
  output logic [OUTPUT_DATA_WIDTH-1:0] data1_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_out
);

  localparam int c_N     = SIZE*SIZE;
  localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N-1);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_loading;
  logic               w_xfer;
  logic               w_cnt_last;

  assign w_loading  = (r_state != S_PRESENT);
  assign w_xfer     = in_valid && w_loading && !flush;
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = w_loading;
    out_valid   = (r_state == S_PRESENT);
    if (flush) begin
      w_state_nxt = S_LOAD_A;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_xfer) begin
            if (w_cnt_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_LOAD_B;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (w_xfer) begin
            if (w_cnt_last) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_PRESENT;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            w_state_nxt = S_LOAD_A;
          end
        end
        default: begin
          w_state_nxt = S_LOAD_A;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Slot k of data1 holds B(r=k%SIZE, c=k/SIZE), i.e. stream index (k%SIZE)*SIZE + k/SIZE.
  for (genvar k = 0; k < c_N; k++) begin : g_elem
    localparam logic [c_CNT_W-1:0] c_SELF = c_CNT_W'(k);
    localparam logic [c_CNT_W-1:0] c_SRC  = c_CNT_W'((k % SIZE)*SIZE + k/SIZE);

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_a <= '0;
        r_b <= '0;
      end else begin
        if (w_xfer && (r_state == S_LOAD_A) && (r_cnt == c_SELF)) begin
          r_a <= in_data;
        end
        if (w_xfer && (r_state == S_LOAD_B) && (r_cnt == c_SRC)) begin
          r_b <= in_data;
        end
      end
    end

    assign data0_out[k*DATA_WIDTH +: DATA_WIDTH] = r_a;
    assign data1_out[k*DATA_WIDTH +: DATA_WIDTH] = r_b;
  end

`ifdef MATRIX_OPERAND_LOADER_FRAME_CHECK_EN
  logic r_err;
  logic w_last_b;

  // in_last must coincide exactly with the final element of B.
  assign w_last_b = (r_state == S_LOAD_B) && w_cnt_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_xfer && (in_last != w_last_b)) begin
      r_err <= 1'b1;
    end
  end

  assign err_out = r_err;
`else
  logic w_unused_in_last;

  assign w_unused_in_last = in_last;
  assign err_out          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the square matrix multiplier.
- Accepts a serial stream of DATA_WIDTH words over a valid/ready handshake: matrix A row-major, then matrix B row-major.
- Packs A as row vectors and B transposed into column vectors on two flat buses.
- Presents both buses, held stable, with a valid/ready handshake whose valid doubles as the multiplier's enable.

Parameters:
- DATA_WIDTH, 32, element width in bits
- SIZE, 4, matrix dimension (SIZE x SIZE)
- OUTPUT_DATA_WIDTH, SIZE*SIZE*DATA_WIDTH (512), width of each packed operand bus; must equal this product

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- in_data  input  DATA_WIDTH  stream element
- in_valid  input  1  in_data valid
- in_last  input  1  marks final element of B (used only with optional feature)
- in_ready  output  1  loader accepts element this cycle
- flush  input  1  synchronous abort of the current load
- data0_out  output  OUTPUT_DATA_WIDTH  A packed: row r in slice r
- data1_out  output  OUTPUT_DATA_WIDTH  B packed: column c in slice c
- out_valid  output  1  operands complete and stable; drives multiplier enable
- out_ready  input  1  consumer accepts operands
- err_out  output  1  sticky stream-framing error (optional feature)

Behaviour:
- N = SIZE*SIZE. Element counter cnt is $clog2(N) bits wide and runs 0..N-1.
- Transfer occurs when in_valid && in_ready.
- States: LOAD_A, LOAD_B, PRESENT.
- in_ready is 1 in LOAD_A and LOAD_B, 0 in PRESENT. in_ready is combinational from state only.
- LOAD_A, transfer of element k = cnt:
  - data0_out[k*DATA_WIDTH +: DATA_WIDTH] <= in_data
  - at cnt = N-1: cnt <= 0, go to LOAD_B; otherwise cnt++
- LOAD_B, transfer of element k (r = k/SIZE, c = k%SIZE):
  - data1_out[(c*SIZE+r)*DATA_WIDTH +: DATA_WIDTH] <= in_data
  - at cnt = N-1: cnt <= 0, go to PRESENT
- PRESENT:
  - out_valid = 1; data0_out and data1_out are held constant
  - on out_ready = 1: return to LOAD_A, out_valid = 0 from the next cycle
  - out_valid never drops without out_ready
- Timing:
  - out_valid rises on the cycle after the last B transfer.
  - Minimum period per operand pair is 2N+1 cycles (33 for SIZE = 4).
  - No cycle skipped when in_valid is held high.
- Buffers are never cleared except by reset; elements not rewritten retain their old values.
- Reset (rst = 0), regardless of state:
  - state LOAD_A, cnt 0
  - data0_out = data1_out = 0
  - out_valid = 0, err_out = 0
  - in_ready is 1 from the first cycle after reset release
- flush = 1 (priority: reset > flush > transfer):
  - next state LOAD_A, cnt 0, out_valid 0
  - buffers untouched
  - any element presented that cycle is dropped even if in_valid = 1
  - flush in PRESENT discards the pending operand pair, even when out_ready = 1 in the same cycle
- in_valid with in_ready = 0 is ignored and the element is not consumed; the upstream holds it.

Optional Feature:
- Macro: MATRIX_OPERAND_LOADER_FRAME_CHECK_EN
- Defined: err_out is set, sticky until reset, on either of:
  - a transfer with in_last = 1 that is not element N-1 of B
  - element N-1 of B transferred with in_last = 0
- Data flow and state transitions are unaffected by the check; the offending element is still accepted.
- Undefined: in_last is ignored, err_out is tied to 0, no check logic is synthesized.

Test Plan:
- SIZE 4, reset then stream A = 1..16, B = 17..32, in_valid held high, out_ready = 0:
  - out_valid rises on cycle 33 after the first transfer
  - data0_out slice0 = {4,3,2,1}
  - data1_out slice0 = {29,25,21,17} (column 0 of B)
  - data1_out slice3 = {32,28,24,20}
- Same stream with out_ready held 0 for 10 cycles in PRESENT while in_valid = 1:
  - in_ready = 0 throughout; outputs constant; no element consumed
  - out_ready = 1 pulse gives out_valid = 0 and in_ready = 1 next cycle
- Random in_valid gaps (about 50% duty) on the same data:
  - identical packed outputs to the first scenario
  - out_valid asserts exactly one cycle after the 32nd transfer
- flush asserted after element 20 (mid-B) with in_valid = 1:
  - that element is dropped; cnt 0, state LOAD_A
  - a fresh 32-element stream of values 100..131 yields data0_out slice0 = {103,102,101,100}
- rst = 0 asserted in PRESENT with out_ready = 1:
  - next cycle out_valid = 0, both buses 0, in_ready = 1, err_out = 0
- With MATRIX_OPERAND_LOADER_FRAME_CHECK_EN, in_last = 1 on element 5 of A:
  - err_out = 1 from the next cycle and stays high
  - load still completes; out_valid asserts normally
- Without the macro, the same stimulus keeps err_out = 0.
